pipe_latch_reader: RTL and testbench

PIPE_LATCH_READER -- requirements
Module: pipe_latch_reader

---
 rtl/pipe_latch_reader.sv | 143 ++++++++++++++
 tb/tb_pipe_latch_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_reader.sv
// pipe_latch_reader
//   Takes a one-shot snapshot of a set of pipeline-latch words and streams it
//   out byte by byte over a valid/ready byte sink (e.g. a UART transmitter).
//   Word 0 goes first, and the least-significant byte of each word goes first.
//   While a snapshot is in progress, o_busy is used externally to freeze the
//   pipeline latches.
//
// Optional feature (macro PIPE_LATCH_READER_CHECKSUM_EN):
//   When defined, one extra byte follows the data bytes. It is the XOR of
//   all data bytes.
//
// Parameters
//   DATA_WIDTH  width of one latch word (multiple of 8), default 32
//   NUM_WORDS   number of latch words per snapshot, default 5
//
// Ports
//   clk         clock, all state updates on the rising edge
//   i_rst_n     synchronous active-low reset
//   i_start     snapshot request, only honoured while idle
//   i_words     flattened latch words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_tx_ready  byte sink can accept a byte
//   o_tx_data   byte presented to the sink (0x00 whenever o_tx_valid is low)
//   o_tx_valid  o_tx_data is valid
//   o_busy      snapshot in progress
//   o_done      one-cycle pulse after the final byte has been accepted

module pipe_latch_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 5
) (
    input  logic                            clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] i_words,
    input  logic                            i_tx_ready,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int TOTAL_BITS = NUM_WORDS * DATA_WIDTH;
    localparam int NUM_BYTES  = TOTAL_BITS / 8;
    localparam int CNT_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
    localparam logic [1:0] CSUM = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [TOTAL_BITS-1:0] buffer;
    logic [TOTAL_BITS-1:0] next_buffer;
    logic [CNT_W-1:0]      count;
    logic                  xfer;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // The buffer shifts right by one byte per transfer, so the byte on the
    // wire is always buffer[7:0]. This avoids a wide variable-index mux.
    assign next_buffer = buffer >> 8;
    assign xfer        = o_tx_valid & i_tx_ready;

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            buffer     <= '0;
            count      <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        buffer     <= i_words;
                        count      <= '0;
                        o_tx_data  <= i_words[7:0];
                        o_tx_valid <= 1'b1;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
                        csum       <= '0;
`endif
                        state      <= SEND;
                    end
                end

                SEND: begin
                    if (xfer) begin
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
                        csum <= csum ^ o_tx_data;
`endif
                        if (count == LAST_IDX) begin
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
                            // Keep valid high so the checksum byte follows
                            // the last data byte with no gap.
                            o_tx_data <= csum ^ o_tx_data;
                            state     <= CSUM;
`else
                            o_tx_data  <= '0;
                            o_tx_valid <= 1'b0;
                            state      <= DONE;
`endif
                        end else begin
                            count     <= count + CNT_W'(1);
                            buffer    <= next_buffer;
                            o_tx_data <= next_buffer[7:0];
                        end
                    end
                end

`ifdef PIPE_LATCH_READER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        o_tx_data  <= '0;
                        o_tx_valid <= 1'b0;
                        state      <= DONE;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    o_tx_data  <= '0;
                    o_tx_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_latch_reader.sv
// tb_pipe_latch_reader
//   Directed self-checking bench for pipe_latch_reader with default
//   parameters. It covers the reset state, a plain stream, a stream with
//   back-pressure, capture isolation with start ignored while busy,
//   reset in mid-snapshot, and a sparse data pattern. With
//   PIPE_LATCH_READER_CHECKSUM_EN defined, the expected streams include the
//   trailing checksum byte.

module tb_pipe_latch_reader;

    localparam int DW = 32;
    localparam int NW = 5;
    localparam int NB = NW * DW / 8;

    logic           clk = 1'b0;
    logic           i_rst_n;
    logic           i_start;
    logic [NW*DW-1:0] i_words;
    logic           i_tx_ready;
    logic [7:0]     o_tx_data;
    logic           o_tx_valid;
    logic           o_busy;
    logic           o_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_b [0:31];
    int         n_exp = 0;

    always #5 clk = ~clk;

    pipe_latch_reader #(
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_words   (i_words),
        .i_tx_ready(i_tx_ready),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, " data"},  32'(o_tx_data),  32'd0);
        check({tag, " busy"},  32'(o_busy),     32'd0);
        check({tag, " done"},  32'(o_done),     32'd0);
    endtask

    // Bytes 0x00..0x13; the XOR of 0..19 is 0x00.
    task automatic load_seq();
        for (int k = 0; k < NB; k++) begin
            i_words[k*8 +: 8] = 8'(k);
            exp_b[k] = 8'(k);
        end
        n_exp = NB;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
        exp_b[NB] = 8'h00;
        n_exp = NB + 1;
`endif
    endtask

    // Word 0 = 0x000000A5, the rest zero; the XOR is 0xA5.
    task automatic load_a5();
        i_words = '0;
        i_words[7:0] = 8'hA5;
        for (int k = 0; k < NB; k++) exp_b[k] = 8'h00;
        exp_b[0] = 8'hA5;
        n_exp = NB;
`ifdef PIPE_LATCH_READER_CHECKSUM_EN
        exp_b[NB] = 8'hA5;
        n_exp = NB + 1;
`endif
    endtask

    // Starts a snapshot at the next edge, then follows it cycle by cycle
    // against exp_b. "toggle" drives ready 1,0,1,0... from cycle 1.
    // A cycle value of 0 for chg_cyc or re_cyc disables that event.
    task automatic run_snapshot(input string tag, input bit toggle,
                                input int chg_cyc, input int re_cyc);
        int idx;
        int post;
        bit finished;
        idx = 0;
        post = 0;
        finished = 1'b0;
        i_start = 1'b1;
        i_tx_ready = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
            i_tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (idx < n_exp) begin
                check({tag, " valid"}, 32'(o_tx_valid), 32'd1);
                check({tag, " data"},  32'(o_tx_data),  32'(exp_b[idx]));
                check({tag, " busy"},  32'(o_busy),     32'd1);
                check({tag, " done"},  32'(o_done),     32'd0);
                if (i_tx_ready) idx++;
            end else begin
                post++;
                check({tag, " end valid"}, 32'(o_tx_valid), 32'd0);
                check({tag, " end data"},  32'(o_tx_data),  32'd0);
                check({tag, " end done"},  32'(o_done),     32'(post == 1));
                check({tag, " end busy"},  32'(o_busy),     32'(post == 1));
                if (post == 3) finished = 1'b1;
            end
            if (cyc == chg_cyc) i_words = '1;
            i_start = (cyc == re_cyc);
            if (!finished) step();
        end
        i_start = 1'b0;
        check({tag, " completed"}, 32'(finished), 32'd1);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_tx_ready = 1'b0;
        i_words    = '0;
        step();
        step();
        check_idle("reset");
        i_rst_n = 1'b1;
        step();
        check_idle("idle");

        load_seq();
        run_snapshot("basic", 1'b0, 0, 0);

        load_seq();
        run_snapshot("stall", 1'b1, 0, 0);

        load_seq();
        run_snapshot("capture", 1'b0, 2, 5);

        // Reset on cycle 7 of a snapshot with start asserted at that edge.
        load_seq();
        i_start = 1'b1;
        i_tx_ready = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            check("pre-rst data",  32'(o_tx_data),  32'(exp_b[cyc-1]));
            check("pre-rst valid", 32'(o_tx_valid), 32'd1);
            step();
        end
        check("cyc7 data", 32'(o_tx_data), 32'(exp_b[6]));
        i_rst_n = 1'b0;
        i_start = 1'b1;
        step();
        check_idle("mid-rst");
        i_rst_n = 1'b1;
        i_start = 1'b0;
        step();
        check_idle("post-rst");
        run_snapshot("restart", 1'b0, 0, 0);

        load_a5();
        run_snapshot("a5", 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
